fp_sm_accum: RTL and testbench
==============================

# fp_sm_accum

Multi-lane streaming accumulator for the sign-magnitude low-precision format used by the nf_tpu datapath: 1 sign bit plus a MAG_W-bit magnitude field, with the field value treated as an unsigned integer magnitude. Each lane sums a packet of input beats into a wide internal accumulator. On the packet's last beat the block emits one clamped sign-magnitude result per lane. It sits between the PE array output and the writeback buffer, replacing per-pair combinational adders with a pipelined, back-pressured reduction.

## Interface
Parameters:
- LANES, 4: number of independent lanes.
- MAG_W, 3: magnitude field width; element width is MAG_W+1.
- CNT_W, 4: beat-counter width; the maximum packet length is 2^CNT_W beats.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_last  in  1  beat closes the packet.
- in_data  in  LANES*(MAG_W+1)  lane l occupies bits [l*(MAG_W+1) +: MAG_W+1]; the MSB of each lane slice is the sign.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  LANES*(MAG_W+1)  clamped per-lane results, packed the same way as in_data.
- out_sat  out  LANES  per-lane saturation flags (see Configuration).

## Operation
- A beat is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. It is 0 while rst is asserted.
- Lane value is (sign ? -mag : +mag). Negative zero (sign=1, mag=0) is treated as 0.
- Accumulator per lane: signed two's complement, ACC_W = MAG_W+CNT_W+1 bits, reset to 0.
  - Each accepted beat adds the lane value to the accumulator.
  - The addition saturates at the ACC_W signed limits. This cannot occur with in-range packets and is a guard only.
- FSM, states IDLE and ACC:
  - IDLE: no beats of the current packet have been accepted; acc=0 and cnt=0.
  - Accepted non-closing beat: go to or stay in ACC; cnt increments.
  - Closing beat: in_last=1, or cnt == 2^CNT_W-1 (auto-close, in_last is ignored). On a closing beat:
    - the final sum (acc plus the current beat) is clamped into the output register;
    - out_valid is set;
    - acc and cnt clear;
    - the FSM returns to IDLE.
- Clamp rules:
  - |sum| > 2^MAG_W-1 gives magnitude 2^MAG_W-1 with the sign of sum, and sets the lane's saturation condition.
  - sum == 0 gives +0 (all zeros).
  - Negative sum gives sign 1 and magnitude |sum|.
- Output handshake:
  - out_valid && out_ready completes the transfer and clears out_valid, unless a closing beat is accepted in the same cycle.
  - In that case the register loads the new result and out_valid stays 1.
  - out_data is held stable while out_valid && !out_ready.

## Timing
- Latency: a closing beat accepted at edge t makes out_valid=1 with the result visible after edge t, i.e. 1 cycle.
- Throughput: one beat per cycle. Back-to-back single-beat packets sustain 1 result per cycle when out_ready=1.
- Reset values: out_valid=0, out_data=0, out_sat=0, acc=0, cnt=0, FSM=IDLE.
- Reset mid-packet discards the partial sums. Reset while out_valid=1 drops the pending result.
- Non-closing beats are also blocked while the output is stalled, because in_ready covers all beats.

## Configuration
- FP_SM_ACCUM_STICKY_SAT_EN defined:
  - out_sat[l] is a registered flag loaded with the lane's clamp condition on each closing beat.
  - The flag also includes any internal ACC_W guard saturation during the packet, held sticky in a per-lane bit that clears at packet close.
  - out_sat is valid under the same rules as out_data.
- Macro undefined: out_sat is tied to 0, and no sticky registers or clamp-detect logic are instantiated.

## Structure
- Shared package fp_sm_pkg holds:
  - the sign-magnitude field helpers: sign bit index, max magnitude constant function of MAG_W;
  - the FSM state enum (IDLE, ACC);
  - functions for sign-magnitude-to-two's-complement conversion and saturating clamp.
- One sub-module, fp_sm_lane, instantiated LANES times. It holds one lane's accumulator, guard saturation, clamp and sticky flag.
- The top level owns the FSM, beat counter, handshake logic and output valid register.

## Test plan
Defaults: LANES=4, MAG_W=3, CNT_W=4.
- Basic sum: lane0 beats 4'b0011, 4'b1101 (last) -> lane0 out 4'b1010 (-2), out_sat[0]=0, out_valid one cycle after the last beat.
- Positive saturation: lane1 beats 4'b0111, 4'b0111 (last) -> 4'b0111; out_sat[1]=1 with macro, 0 without. Negative case: 4'b1111 x2 -> 4'b1111.
- Zero handling: lane2 beats 4'b1000, 4'b0101, 4'b1101 (last) -> 4'b0000 (not 4'b1000).
- Backpressure: hold out_ready=0 with a result pending -> in_ready=0 and out_data stable for 5 cycles. Raise out_ready while a closing beat is valid -> new result loads the same cycle and out_valid stays 1.
- Auto-close: 16 beats of 4'b0000 except one 4'b0001, in_last never asserted -> result 4'b0001 after the 16th beat; the 17th beat starts a new packet.
- Reset mid-packet: 3 beats of 4'b0010, then rst pulse, then one beat 4'b0001 (last) -> out 4'b0001, with all outputs 0 during reset.

Source files
------------

// File: rtl/fp_sm_pkg.sv
// -----------------------------------------------------------------------------
// fp_sm_pkg
// Shared definitions for the sign-magnitude accumulator:
//   - FSM state enum (IDLE, ACC)
//   - field helpers: sign bit index and maximum magnitude for a MAG_W field
//   - sign-magnitude -> two's complement conversion
//   - saturating clamp of a two's complement sum back to sign-magnitude
// The functions work on 32-bit zero/sign-extended values so they serve any
// MAG_W / accumulator width up to 32 bits; callers cast results to their width.
// -----------------------------------------------------------------------------
package fp_sm_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      ACC  = 1'b1
   } fsm_state_e;

   function automatic int unsigned sm_sign_idx(input int unsigned mag_w);
      return mag_w;
   endfunction

   function automatic int unsigned sm_max_mag(input int unsigned mag_w);
      return (32'd1 << mag_w) - 32'd1;
   endfunction

   // elem is the element zero-extended to 32 bits. Negative zero yields 0.
   function automatic logic signed [31:0] sm_to_tc(input logic [31:0]   elem,
                                                   input int unsigned   mag_w);
      logic [31:0] mag;
      logic        sgn;
      mag = elem & sm_max_mag(mag_w);
      sgn = |(elem & (32'd1 << sm_sign_idx(mag_w)));
      if (sgn) begin
         return -$signed(mag);
      end
      return $signed(mag);
   endfunction

   // Clamp a signed sum into a sign-magnitude element (zero-extended result).
   // A zero sum always produces +0.
   function automatic logic [31:0] sm_clamp(input logic signed [31:0] sum,
                                            input int unsigned        mag_w);
      logic [31:0] abs_v;
      logic [31:0] mag;
      abs_v = sum[31] ? $unsigned(-sum) : $unsigned(sum);
      mag   = (abs_v > sm_max_mag(mag_w)) ? sm_max_mag(mag_w) : abs_v;
      return sum[31] ? ((32'd1 << sm_sign_idx(mag_w)) | mag) : mag;
   endfunction

   // True when the clamp above had to limit the magnitude.
   function automatic logic sm_clamp_sat(input logic signed [31:0] sum,
                                         input int unsigned        mag_w);
      logic [31:0] abs_v;
      abs_v = sum[31] ? $unsigned(-sum) : $unsigned(sum);
      return abs_v > sm_max_mag(mag_w);
   endfunction

endpackage

// File: rtl/fp_sm_lane.sv
// -----------------------------------------------------------------------------
// fp_sm_lane
// One lane of the sign-magnitude accumulator: wide signed accumulator with
// guard saturation, clamp to sign-magnitude and the registered lane result.
// Optional feature macro: FP_SM_ACCUM_STICKY_SAT_EN (saturation flag path).
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   beat_en    a beat is accepted this cycle
//   close_en   the accepted beat closes the packet (implies beat_en)
//   in_elem    sign-magnitude input element (MSB = sign)
//   out_elem   registered clamped result
//   out_sat    registered saturation flag (0 when the macro is undefined)
// -----------------------------------------------------------------------------
module fp_sm_lane
   import fp_sm_pkg::*;
#(
   parameter int MAG_W = 3,
   parameter int CNT_W = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           beat_en,
   input  logic           close_en,
   input  logic [MAG_W:0] in_elem,
   output logic [MAG_W:0] out_elem,
   output logic           out_sat
);

   localparam int ACC_W = MAG_W + CNT_W + 1;

   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] lane_val;
   logic        [ACC_W:0]   sum_wide;
   logic signed [ACC_W-1:0] sum_sat;
   logic signed [31:0]      sum_ext;
   logic                    guard_ovf;
   logic        [MAG_W:0]   elem_q, elem_d;
   logic        [MAG_W:0]   clamp_elem;

   assign lane_val = ACC_W'(sm_to_tc(32'(in_elem), MAG_W));

   // One extra bit lets us see a signed overflow of the ACC_W-bit sum.
   assign sum_wide  = {acc_q[ACC_W-1], acc_q} + {lane_val[ACC_W-1], lane_val};
   assign guard_ovf = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

   always_comb begin
      sum_sat = sum_wide[ACC_W-1:0];
      if (guard_ovf) begin
         sum_sat = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                   : {1'b0, {(ACC_W-1){1'b1}}};
      end
   end

   assign sum_ext    = {{(32-ACC_W){sum_sat[ACC_W-1]}}, sum_sat};
   assign clamp_elem = (MAG_W+1)'(sm_clamp(sum_ext, MAG_W));

   always_comb begin
      acc_d  = acc_q;
      elem_d = elem_q;
      if (close_en) begin
         acc_d  = '0;
         elem_d = clamp_elem;
      end else if (beat_en) begin
         acc_d  = sum_sat;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q  <= '0;
         elem_q <= '0;
      end else begin
         acc_q  <= acc_d;
         elem_q <= elem_d;
      end
   end

   assign out_elem = elem_q;

`ifdef FP_SM_ACCUM_STICKY_SAT_EN
   logic sticky_q, sticky_d;
   logic sat_q, sat_d;
   logic clamp_sat;

   assign clamp_sat = sm_clamp_sat(sum_ext, MAG_W);

   // The sticky bit remembers a guard overflow on an earlier beat of the
   // packet; the closing beat folds it into the output flag and clears it.
   always_comb begin
      sticky_d = sticky_q;
      sat_d    = sat_q;
      if (close_en) begin
         sticky_d = 1'b0;
         sat_d    = clamp_sat | sticky_q | guard_ovf;
      end else if (beat_en && guard_ovf) begin
         sticky_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_q <= 1'b0;
         sat_q    <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
         sat_q    <= sat_d;
      end
   end

   assign out_sat = sat_q;
`else
   assign out_sat = 1'b0;
`endif

endmodule

// File: rtl/fp_sm_accum.sv
// -----------------------------------------------------------------------------
// fp_sm_accum
// Multi-lane streaming accumulator for sign-magnitude elements. Each lane sums
// the beats of a packet; the closing beat (in_last, or the 2^CNT_W-th beat)
// loads one clamped sign-magnitude result per lane into the output register.
// Optional feature macro: FP_SM_ACCUM_STICKY_SAT_EN enables out_sat flags;
// without it out_sat is constant 0.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    input beat handshake
//   in_last              beat closes the packet
//   in_data              LANES elements of MAG_W+1 bits, lane l at l*(MAG_W+1)
//   out_valid/out_ready  result handshake
//   out_data             clamped per-lane results, packed like in_data
//   out_sat              per-lane saturation flags
// -----------------------------------------------------------------------------
module fp_sm_accum
   import fp_sm_pkg::*;
#(
   parameter int LANES = 4,
   parameter int MAG_W = 3,
   parameter int CNT_W = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_last,
   input  logic [LANES*(MAG_W+1)-1:0] in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [LANES*(MAG_W+1)-1:0] out_data,
   output logic [LANES-1:0]           out_sat
);

   localparam int EW = MAG_W + 1;

   fsm_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic             accept;
   logic             cnt_full;
   logic             close_beat;

   // A single output register: any beat waits while a result is stalled.
   assign in_ready   = !rst && (!out_valid_q || out_ready);
   assign accept     = in_valid && in_ready;
   // cnt only reaches all-ones after 2^CNT_W-1 accepted beats, i.e. in ACC.
   assign cnt_full   = (state_q == ACC) && (cnt_q == {CNT_W{1'b1}});
   assign close_beat = accept && (in_last || cnt_full);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      if (out_ready) begin
         out_valid_d = 1'b0;
      end
      if (close_beat) begin
         state_d     = IDLE;
         cnt_d       = '0;
         out_valid_d = 1'b1;
      end else if (accept) begin
         state_d     = ACC;
         cnt_d       = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      fp_sm_lane #(
         .MAG_W (MAG_W),
         .CNT_W (CNT_W)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .beat_en  (accept),
         .close_en (close_beat),
         .in_elem  (in_data[gi*EW +: EW]),
         .out_elem (out_data[gi*EW +: EW]),
         .out_sat  (out_sat[gi])
      );
   end

endmodule

// File: tb/tb_fp_sm_accum.sv
// -----------------------------------------------------------------------------
// tb_fp_sm_accum
// Self-checking bench for fp_sm_accum (LANES=4, MAG_W=3, CNT_W=4).
// Expected results are queued when a closing beat is accepted and compared
// when the DUT transfers a result. Saturation flags are expected only when
// FP_SM_ACCUM_STICKY_SAT_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fp_sm_accum;

   localparam int LANES = 4;
   localparam int MAG_W = 3;
   localparam int CNT_W = 4;
   localparam int EW    = MAG_W + 1;
   localparam int DW    = LANES * EW;
`ifdef FP_SM_ACCUM_STICKY_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic          in_last;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [LANES-1:0] out_sat;

   always #5 clk = ~clk;

   fp_sm_accum #(
      .LANES (LANES),
      .MAG_W (MAG_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_last   (in_last),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat)
   );

   typedef struct packed {
      logic [DW-1:0]    data;
      logic [LANES-1:0] sat;
   } sb_t;

   typedef struct {
      logic [DW-1:0]    data;
      logic             last;
      logic [DW-1:0]    exp_data;
      logic [LANES-1:0] exp_sat;
   } vec_t;

   sb_t  sb_q[$];
   vec_t vecs[12];
   int   checks   = 0;
   int   failures = 0;
   int   txn      = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Compares every completed output transfer against the scoreboard head.
   task automatic monitor();
      sb_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result: got out_data=%h with no result expected", out_data);
            end else begin
               e = sb_q.pop_front();
               txn++;
               $display("txn %0d out_data=%h out_sat=%b (required %h %b)",
                        txn, out_data, out_sat, e.data, e.sat);
               check("out_data", 32'(out_data), 32'(e.data));
               check("out_sat", 32'(out_sat), 32'(e.sat));
            end
         end
      end
   endtask

   // Drive one beat until accepted; queue the expected result if it closes.
   task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic closes,
                            input logic [DW-1:0] ed, input logic [LANES-1:0] es);
      int  tries;
      bit  done;
      sb_t e;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      tries    = 0;
      done     = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            done = 1'b1;
            if (closes) begin
               e.data = ed;
               e.sat  = SAT_EN ? es : '0;
               sb_q.push_back(e);
            end
         end else begin
            tries++;
            if (tries > 50) begin
               checks++;
               failures++;
               $display("FAIL in_ready_timeout: in_ready=0 for %0d cycles, required 1", tries);
               done = 1'b1;
            end
         end
         @(posedge clk);
         #1;
         if (!done) out_ready = 1'b1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while ((sb_q.size() != 0 || out_valid) && n < 30) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_pending", 32'(sb_q.size()), 32'd0);
   endtask

   function automatic void model_clamp(input int s, output logic [EW-1:0] e, output logic sat);
      int a;
      a   = (s < 0) ? -s : s;
      sat = (a > 7);
      if (a > 7) a = 7;
      e = (s == 0) ? '0 : {(s < 0), 3'(a)};
   endfunction

   initial begin
      logic [DW-1:0]    d, ed;
      logic [LANES-1:0] es;
      logic [EW-1:0]    el;
      logic             sl, last, closes;
      int               acc[LANES];
      int               cnt;
      int               v;

      vecs[0]  = '{16'h0003, 1'b0, 16'h0000, 4'b0000};
      vecs[1]  = '{16'h000D, 1'b1, 16'h000A, 4'b0000};  // 3 + (-5) = -2
      vecs[2]  = '{16'hF070, 1'b0, 16'h0000, 4'b0000};
      vecs[3]  = '{16'hF070, 1'b1, 16'hF070, 4'b1010};  // +14 -> +7, -14 -> -7
      vecs[4]  = '{16'h0800, 1'b0, 16'h0000, 4'b0000};
      vecs[5]  = '{16'h0500, 1'b0, 16'h0000, 4'b0000};
      vecs[6]  = '{16'h0D00, 1'b1, 16'h0000, 4'b0000};  // -0 + 5 - 5 = +0
      vecs[7]  = '{16'h1234, 1'b1, 16'h1234, 4'b0000};
      vecs[8]  = '{16'h9ABC, 1'b1, 16'h9ABC, 4'b0000};
      vecs[9]  = '{16'h8888, 1'b1, 16'h0000, 4'b0000};  // negative zeros
      vecs[10] = '{16'h7777, 1'b0, 16'h0000, 4'b0000};
      vecs[11] = '{16'h1111, 1'b1, 16'h7777, 4'b1111};  // +8 -> +7 on all lanes

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      fork
         monitor();
      join_none

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_sat", 32'(out_sat), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Table-driven packets, back to back with out_ready held high
      for (int i = 0; i < 12; i++) begin
         send_beat(vecs[i].data, vecs[i].last, vecs[i].last, vecs[i].exp_data, vecs[i].exp_sat);
      end
      drain();

      // Backpressure: stalled result blocks input and holds out_data
      out_ready = 1'b0;
      send_beat(16'h0001, 1'b1, 1'b1, 16'h0001, 4'b0000);
      check("latency_out_valid", 32'(out_valid), 32'd1);
      check("latency_out_data", 32'(out_data), 32'h0001);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_out_data", 32'(out_data), 32'h0001);
         @(posedge clk);
         #1;
      end
      // Release while a closing beat waits: new result loads the same edge
      out_ready = 1'b1;
      send_beat(16'h0002, 1'b1, 1'b1, 16'h0002, 4'b0000);
      check("reload_out_valid", 32'(out_valid), 32'd1);
      check("reload_out_data", 32'(out_data), 32'h0002);
      drain();

      // Auto-close after 16 beats without in_last
      for (int b = 0; b < 16; b++) begin
         d = (b == 5) ? 16'h0001 : 16'h0000;
         send_beat(d, 1'b0, (b == 15), 16'h0001, 4'b0000);
         if (b == 14) check("autoclose_early", 32'(out_valid), 32'd0);
      end
      check("autoclose_valid", 32'(out_valid), 32'd1);
      check("autoclose_data", 32'(out_data), 32'h0001);
      send_beat(16'h0002, 1'b1, 1'b1, 16'h0002, 4'b0000);
      drain();

      // Reset mid-packet discards partial sums
      for (int b = 0; b < 3; b++) begin
         send_beat(16'h0002, 1'b0, 1'b0, 16'h0000, 4'b0000);
      end
      rst = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      check("midrst_out_data", 32'(out_data), 32'd0);
      check("midrst_out_sat", 32'(out_sat), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      send_beat(16'h0001, 1'b1, 1'b1, 16'h0001, 4'b0000);
      drain();

      // Random packets with random backpressure, checked against a model
      for (int l = 0; l < LANES; l++) acc[l] = 0;
      cnt = 0;
      for (int n = 0; n < 80; n++) begin
         d         = DW'($urandom);
         last      = ($urandom_range(0, 3) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         closes    = last || (cnt == (1 << CNT_W) - 1);
         ed        = '0;
         es        = '0;
         for (int l = 0; l < LANES; l++) begin
            el = d[l*EW +: EW];
            v  = int'(el[MAG_W-1:0]);
            acc[l] += el[MAG_W] ? -v : v;
            if (closes) begin
               model_clamp(acc[l], el, sl);
               ed[l*EW +: EW] = el;
               es[l] = sl;
               acc[l] = 0;
            end
         end
         cnt = closes ? 0 : cnt + 1;
         send_beat(d, last, closes, ed, es);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
